// File: rtl/sram_pkg.sv
// Shared definitions for the multi-port SRAM: state encoding, packed-field
// indexing and the write-port priority rule used for collisions and bypass.
package sram_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int MAX_ADDR_W = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int field_base(input int i, input int w);
        return i * w;
    endfunction

    // Returns the lowest-index enabled port whose address matches addr, or -1.
    function automatic int win_port(
        input logic [MAX_PORTS*MAX_ADDR_W-1:0] addrs,
        input logic [MAX_PORTS-1:0]            ens,
        input logic [MAX_ADDR_W-1:0]           addr
    );
        int win;
        win = -1;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (ens[i] && (addrs[i*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
                win = i;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Post-reset clear sequencer: sweeps every address once writing zero, holding
// busy high until the final word is written.
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk_In,
    input  logic              Reset_In,
    output logic              busy,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output logic [DATA_W-1:0] clear_data
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (state_reg == ST_CLEAR) begin
            ptr_next = ptr_reg + 1'b1;
            if (ptr_reg == '1) begin
                state_next = ST_READY;
            end
        end
    end

    always_comb begin
        busy       = (state_reg == ST_CLEAR);
        clear_we   = (state_reg == ST_CLEAR);
        clear_addr = ptr_reg;
        clear_data = '0;
    end

endmodule

// File: rtl/sram_multiport_param.sv
// Parametrised multi-port synchronous SRAM with hardware clear, lowest-port-wins
// write collision handling and selectable read-during-write behaviour.
module sram_multiport_param
    import sram_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int NUM_W       = 2,
    parameter int NUM_R       = 2,
    parameter int WRITE_FIRST = 1
) (
    input  logic                    Clk_In,
    input  logic                    Reset_In,
    input  logic [NUM_W*DATA_W-1:0] Wr_Data_In,
    input  logic [NUM_W*ADDR_W-1:0] Wr_Addr_In,
    input  logic [NUM_W-1:0]        Wr_En_In,
    input  logic [NUM_R*ADDR_W-1:0] Rd_Addr_In,
    input  logic [NUM_R-1:0]        Rd_En_In,
    output logic [NUM_R*DATA_W-1:0] Rd_Data_Out,
    output logic [NUM_R-1:0]        Rd_Valid_Out,
    output logic                    Busy_Out,
    output logic                    Collision_Out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic [DATA_W-1:0] clear_data;
    logic              ready;

    sram_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_clear_fsm (
        .Clk_In     (Clk_In),
        .Reset_In   (Reset_In),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .clear_data (clear_data)
    );

    assign ready    = ~busy;
    assign Busy_Out = busy;

    // Write ports widened to the package maximum so the priority function has one shape.
    logic [MAX_PORTS*MAX_ADDR_W-1:0] wr_addr_wide;
    logic [MAX_PORTS*DATA_W-1:0]     wr_data_wide;
    logic [MAX_PORTS-1:0]            wr_en_wide;
    logic [NUM_W-1:0]                commit;
    logic                            collision_reg;

    for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_wr_wide
        if (gi < NUM_W) begin : g_used
            assign wr_addr_wide[gi*MAX_ADDR_W +: MAX_ADDR_W] =
                MAX_ADDR_W'(Wr_Addr_In[field_base(gi, ADDR_W) +: ADDR_W]);
            assign wr_data_wide[gi*DATA_W +: DATA_W] = Wr_Data_In[field_base(gi, DATA_W) +: DATA_W];
            assign wr_en_wide[gi] = Wr_En_In[gi] & ready;
        end else begin : g_unused
            assign wr_addr_wide[gi*MAX_ADDR_W +: MAX_ADDR_W] = '0;
            assign wr_data_wide[gi*DATA_W +: DATA_W] = '0;
            assign wr_en_wide[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_W; gi++) begin : g_commit
        assign commit[gi] = wr_en_wide[gi] &&
            (win_port(wr_addr_wide, wr_en_wide, wr_addr_wide[gi*MAX_ADDR_W +: MAX_ADDR_W]) == gi);
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= |(wr_en_wide[NUM_W-1:0] & ~commit);
        end
    end

    assign Collision_Out = collision_reg;

    // Committed ports always target distinct addresses, so loop order is irrelevant.
    always_ff @(posedge Clk_In) begin
        if (clear_we) begin
            mem[clear_addr] <= clear_data;
        end else begin
            for (int i = 0; i < NUM_W; i++) begin
                if (commit[i]) begin
                    mem[wr_addr_wide[i*MAX_ADDR_W +: ADDR_W]] <= wr_data_wide[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_R; gi++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        int                rd_win;
        logic [DATA_W-1:0] rdw_data;
        logic [DATA_W-1:0] rd_data_reg;
        logic              rd_valid_reg;

        assign rd_addr = Rd_Addr_In[field_base(gi, ADDR_W) +: ADDR_W];
        assign rd_win  = win_port(wr_addr_wide, wr_en_wide, MAX_ADDR_W'(rd_addr));

        always_comb begin
            rdw_data = mem[rd_addr];
            if ((WRITE_FIRST != 0) && (rd_win >= 0)) begin
                rdw_data = wr_data_wide[rd_win*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge Clk_In or posedge Reset_In) begin
            if (Reset_In) begin
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
            end else if (ready && Rd_En_In[gi]) begin
                rd_data_reg  <= rdw_data;
                rd_valid_reg <= 1'b1;
            end else begin
                rd_valid_reg <= 1'b0;
            end
        end

        assign Rd_Data_Out[field_base(gi, DATA_W) +: DATA_W] = rd_data_reg;
        assign Rd_Valid_Out[gi] = rd_valid_reg;
    end

endmodule

// File: tb/tb_sram_multiport_param.sv
// Bench for sram_multiport_param: write-first and read-first instances share
// stimulus and are checked every cycle against a behavioural memory model.
module tb_sram_multiport_param;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int NW    = 2;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NW*DW-1:0]   wr_data;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW-1:0]      wr_en;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR-1:0]      rd_en;

    logic [NR*DW-1:0]   rd_data_a, rd_data_b;
    logic [NR-1:0]      rd_valid_a, rd_valid_b;
    logic               busy_a, busy_b, coll_a, coll_b;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    sram_multiport_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_W(NW), .NUM_R(NR), .WRITE_FIRST(1)) dut_a (
        .Clk_In(clk), .Reset_In(rst), .Wr_Data_In(wr_data), .Wr_Addr_In(wr_addr), .Wr_En_In(wr_en),
        .Rd_Addr_In(rd_addr), .Rd_En_In(rd_en), .Rd_Data_Out(rd_data_a), .Rd_Valid_Out(rd_valid_a),
        .Busy_Out(busy_a), .Collision_Out(coll_a)
    );

    sram_multiport_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_W(NW), .NUM_R(NR), .WRITE_FIRST(0)) dut_b (
        .Clk_In(clk), .Reset_In(rst), .Wr_Data_In(wr_data), .Wr_Addr_In(wr_addr), .Wr_En_In(wr_en),
        .Rd_Addr_In(rd_addr), .Rd_En_In(rd_en), .Rd_Data_Out(rd_data_b), .Rd_Valid_Out(rd_valid_b),
        .Busy_Out(busy_b), .Collision_Out(coll_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mdl_mem [DEPTH];
    int            clear_left;
    logic          exp_busy, exp_coll;
    logic [DW-1:0] exp_data_new [NR];
    logic [DW-1:0] exp_data_old [NR];
    logic          exp_valid [NR];
    bit            m_win [NW];
    logic [AW-1:0] m_ra;
    logic [DW-1:0] m_old, m_new;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left = DEPTH;
            exp_busy   = 1'b1;
            exp_coll   = 1'b0;
            for (int j = 0; j < NR; j++) begin
                exp_valid[j] = 1'b0; exp_data_new[j] = '0; exp_data_old[j] = '0;
            end
        end else if (clear_left > 0) begin
            clear_left = clear_left - 1;
            exp_coll   = 1'b0;
            for (int j = 0; j < NR; j++) exp_valid[j] = 1'b0;
            if (clear_left == 0) begin
                for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
                exp_busy = 1'b0;
            end
        end else begin
            exp_coll = 1'b0;
            for (int i = 0; i < NW; i++) begin
                m_win[i] = wr_en[i];
                for (int k = 0; k < i; k++) begin
                    if (wr_en[i] && wr_en[k] && wr_addr[k*AW +: AW] == wr_addr[i*AW +: AW]) begin
                        m_win[i] = 1'b0;
                        exp_coll = 1'b1;
                    end
                end
            end
            for (int j = 0; j < NR; j++) begin
                exp_valid[j] = rd_en[j];
                if (rd_en[j]) begin
                    m_ra  = rd_addr[j*AW +: AW];
                    m_old = mdl_mem[m_ra];
                    m_new = m_old;
                    for (int i = 0; i < NW; i++)
                        if (m_win[i] && wr_addr[i*AW +: AW] == m_ra) m_new = wr_data[i*DW +: DW];
                    exp_data_new[j] = m_new;
                    exp_data_old[j] = m_old;
                end
            end
            for (int i = 0; i < NW; i++)
                if (m_win[i]) mdl_mem[wr_addr[i*AW +: AW]] = wr_data[i*DW +: DW];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy_a", 32'(busy_a), 32'(exp_busy));
            check("busy_b", 32'(busy_b), 32'(exp_busy));
            check("coll_a", 32'(coll_a), 32'(exp_coll));
            check("coll_b", 32'(coll_b), 32'(exp_coll));
            for (int j = 0; j < NR; j++) begin
                check($sformatf("valid_a[%0d]", j), 32'(rd_valid_a[j]), 32'(exp_valid[j]));
                check($sformatf("valid_b[%0d]", j), 32'(rd_valid_b[j]), 32'(exp_valid[j]));
                check($sformatf("data_a[%0d]", j), 32'(rd_data_a[j*DW +: DW]), 32'(exp_data_new[j]));
                check($sformatf("data_b[%0d]", j), 32'(rd_data_b[j*DW +: DW]), 32'(exp_data_old[j]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy_a && n < 2000) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        rst = 1'b1;
        wr_data = '0; wr_addr = '0; wr_en = '0; rd_addr = '0; rd_en = '0;
        repeat (3) tick();
        chk_on = 1'b1;

        // Clear sequence with write/read attempts that must be ignored
        rst = 1'b0;
        wr_en = 2'b01; wr_addr[0 +: AW] = 8'h05; wr_data[0 +: DW] = 8'hFF;
        rd_en = 2'b11; rd_addr = {8'h05, 8'h05};
        count_busy("busy_len_first");
        idle();

        // Addresses 0..15 read back as zero after the clear
        for (int k = 0; k < 8; k++) begin
            rd_en = 2'b11;
            rd_addr = {8'(2*k+1), 8'(2*k)};
            tick();
            check($sformatf("clr_rd_%0d", 2*k), 32'(rd_data_a), 32'h0);
            check($sformatf("clr_valid_%0d", 2*k), 32'(rd_valid_a), 32'h3);
        end
        idle();

        // Two distinct writes, then readback
        wr_en = 2'b11; wr_addr = {8'h20, 8'h10}; wr_data = {8'h5A, 8'hA5};
        tick();
        idle();
        rd_en = 2'b11; rd_addr = {8'h20, 8'h10};
        tick();
        check("dist_rd_a", 32'(rd_data_a), 32'h5AA5);
        check("dist_rd_b", 32'(rd_data_b), 32'h5AA5);
        check("dist_valid", 32'(rd_valid_a), 32'h3);
        idle();
        tick();
        check("valid_drop", 32'(rd_valid_a), 32'h0);
        check("data_hold", 32'(rd_data_a), 32'h5AA5);

        // Collision: port 0 must win
        wr_en = 2'b11; wr_addr = {8'h30, 8'h30}; wr_data = {8'h22, 8'h11};
        tick();
        check("coll_pulse", 32'(coll_a), 32'h1);
        idle();
        rd_en = 2'b01; rd_addr[0 +: AW] = 8'h30;
        tick();
        check("coll_end", 32'(coll_a), 32'h0);
        check("coll_winner", 32'(rd_data_a[0 +: DW]), 32'h11);
        idle();

        // Read-during-write
        wr_en = 2'b01; wr_addr[0 +: AW] = 8'h40; wr_data[0 +: DW] = 8'h01;
        tick();
        wr_data[0 +: DW] = 8'h02;
        rd_en = 2'b01; rd_addr[0 +: AW] = 8'h40;
        tick();
        check("rdw_write_first", 32'(rd_data_a[0 +: DW]), 32'h02);
        check("rdw_read_first", 32'(rd_data_b[0 +: DW]), 32'h01);
        idle();
        rd_en = 2'b01;
        tick();
        check("rdw_after", 32'(rd_data_b[0 +: DW]), 32'h02);
        idle();

        // Reset in the middle of the clear sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("midclr_busy", 32'(busy_a), 32'h1);
        check("midclr_valid", 32'(rd_valid_a), 32'h0);
        check("midclr_data", 32'(rd_data_a), 32'h0);
        tick();
        rst = 1'b0;
        count_busy("busy_len_restart");

        // Randomised traffic over a small address window to provoke collisions
        for (int c = 0; c < 600; c++) begin
            wr_en = 2'($urandom_range(0, 3));
            rd_en = 2'($urandom_range(0, 3));
            for (int p = 0; p < NW; p++) begin
                wr_addr[p*AW +: AW] = 8'($urandom_range(0, 15));
                wr_data[p*DW +: DW] = 8'($urandom);
            end
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = 8'($urandom_range(0, 15));
            tick();
        end
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_multiport_param.md
Name: sram_multiport_param

Overview:
- Parametrised multi-port synchronous SRAM: NUM_W independent write ports and NUM_R independent read ports, all on one clock.
- Next-generation data-storage block for register files and shared buffers.
- Adds to the fixed 8-bit four-port generation:
  - hardware memory clear after reset
  - deterministic write-collision resolution with a collision flag
  - selectable read-during-write behaviour
  - per-port read-valid strobes

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- NUM_W, 2, number of write ports (1..8).
- NUM_R, 2, number of read ports (1..8).
- WRITE_FIRST, 1, same-cycle read/write to the same address: 1 returns new data, 0 returns old data.

Ports:
- Clk_In  input  1  clock; all state updates on the rising edge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Wr_Data_In  input  NUM_W*DATA_W  write data; port i occupies bits [i*DATA_W +: DATA_W].
- Wr_Addr_In  input  NUM_W*ADDR_W  write address, packed per port in the same way.
- Wr_En_In  input  NUM_W  per-port write enable.
- Rd_Addr_In  input  NUM_R*ADDR_W  read address, packed per port.
- Rd_En_In  input  NUM_R  per-port read enable.
- Rd_Data_Out  output  NUM_R*DATA_W  registered read data, packed per port.
- Rd_Valid_Out  output  NUM_R  per-port read data valid.
- Busy_Out  output  1  high while the post-reset clear sequence runs.
- Collision_Out  output  1  one-cycle pulse: two or more write ports hit the same address in one cycle.

Behaviour:
- While Reset_In is high:
  - Rd_Data_Out = 0, Rd_Valid_Out = 0, Collision_Out = 0, Busy_Out = 1.
  - FSM = CLEAR, clear pointer = 0.
- FSM:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. When ptr == DEPTH-1, that word is written and the FSM moves to READY. CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - READY: normal operation; stays there until the next reset.
  - Busy_Out = 1 in CLEAR, 0 in READY. It falls on the edge that writes the last word.
- During CLEAR:
  - All Wr_En_In are ignored; no write occurs.
  - Rd_En_In is ignored: Rd_Valid_Out stays 0, Rd_Data_Out stays 0.
  - Collision_Out stays 0.
- Reset asserted mid-CLEAR or mid-READY: immediate return to the reset values above. The clear restarts from address 0; memory contents are undefined until the clear completes.
- Write (READY): on a rising edge with Wr_En_In[i]=1, mem[Wr_Addr_In[i]] <= Wr_Data_In[i].
- Write collision: if several enabled ports share an address, the lowest-index port wins and the others are dropped. Collision_Out = 1 on the following cycle only. Writes to distinct addresses all commit in the same cycle.
- Read (READY): read latency is 1 cycle.
  - Rd_En_In[j]=1 at edge n: Rd_Data_Out[j] = mem[Rd_Addr_In[j]] and Rd_Valid_Out[j] = 1, both after edge n.
  - Rd_En_In[j]=0: Rd_Valid_Out[j] = 0 and Rd_Data_Out[j] holds its last value. No tri-state.
- Read-during-write, same address, same edge:
  - WRITE_FIRST=1: returns the winning port's write data.
  - WRITE_FIRST=0: returns the pre-write content.
- Multiple read ports may read the same address simultaneously.
- Addresses cover the full 2**ADDR_W range; there is no out-of-range case.

Decomposition:
- Package sram_pkg holds:
  - the CLEAR/READY state encoding constants
  - a function for the packed-field index (base = i*W)
  - a function returning the lowest-index winning write port for a given address
- One natural sub-module: sram_clear_fsm (state register, clear pointer, Busy_Out, clear write-enable/address/data).
- Memory array, write-port merge, read ports and collision detection stay in the top level.

Test Plan:
1. Reset behaviour, ADDR_W=4: pulse Reset_In, then release.
   - Busy_Out = 1 for exactly 16 cycles, then 0.
   - Reads of addresses 0..15 return 0x00 with Rd_Valid_Out = 1 one cycle after Rd_En_In.
2. Two distinct writes: write port 0 {addr 0x10, 0xA5} and port 1 {addr 0x20, 0x5A} in one cycle.
   - Next cycle, read ports 0/1 at 0x10/0x20 return 0xA5/0x5A after 1 cycle, valid = 1.
3. Write collision: port 0 writes 0x11 and port 1 writes 0x22, both to 0x30, same cycle.
   - Collision_Out = 1 for exactly one cycle.
   - A later read of 0x30 returns 0x11.
4. Read-during-write: mem[0x40] = 0x01; write 0x02 to 0x40 while reading 0x40 on the same edge.
   - WRITE_FIRST=1: Rd_Data_Out = 0x02.
   - WRITE_FIRST=0: Rd_Data_Out = 0x01.
5. Activity during CLEAR: assert Wr_En_In (addr 0x05, 0xFF) and Rd_En_In during CLEAR.
   - Rd_Valid_Out stays 0.
   - After Busy_Out falls, a read of 0x05 returns 0x00.
6. Reset mid-CLEAR: assert Reset_In at clear-cycle 7.
   - Outputs return to reset values immediately.
   - After release, Busy_Out stays high for a full DEPTH cycles again.
